// File: rtl/mips_ctrl_if.sv
// Signal bundle between the multicycle MIPS control FSM and its datapath.
// The datapath drives the IR fields, the ALU zero flag and mem_ready. The controller drives everything else.
interface mips_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_en;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_ctrl;
    logic [1:0]       pc_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] retired;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state, retired
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal, state, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. It steps through fetch, decode, execute, memory and writeback.
// It also keeps a count of retired instructions and flags unsupported encodings.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    mips_ctrl_if.slave bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
        S_BEQEX   = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JEX    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR = 3'b001, ALU_SLT = 3'b111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;

    logic       pc_write, branch, retire, funct_ok;
    logic       ir_write_c, mem_write_c, reg_write_c, illegal_c;
    logic [2:0] funct_alu;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop then samples its pre-edge value.
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case statement. A state that omits an output therefore cannot infer a latch.
        state_d       = state_q;
        pc_write      = 1'b0;
        branch        = 1'b0;
        retire        = 1'b0;
        ir_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        reg_write_c   = 1'b0;
        illegal_c     = 1'b0;
        bus.iord      = 1'b0;
        bus.reg_dst   = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'b00;
        bus.alu_ctrl  = 3'b000;
        bus.pc_src    = 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = 2'b01;
                bus.alu_ctrl  = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                bus.alu_ctrl  = ALU_ADD;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = funct_ok ? S_RTEX : S_ILLEGAL;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_ctrl  = ALU_ADD;
                state_d       = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                reg_write_c    = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord    = 1'b1;
                mem_write_c = bus.mem_ready;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_RTEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = funct_alu;
                state_d       = S_RTWB;
            end
            S_RTWB: begin
                bus.reg_dst = 1'b1;
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = ALU_SUB;
                bus.pc_src    = 2'b01;
                branch        = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                bus.alu_ctrl  = ALU_ADD;
                state_d       = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JEX: begin
                pc_write   = 1'b1;
                bus.pc_src = 2'b10;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are held low while reset is asserted. The mux selects may still toggle during that time.
    assign bus.pc_en     = rst_n & (pc_write | (branch & bus.zero));
    assign bus.ir_write  = rst_n & ir_write_c;
    assign bus.mem_write = rst_n & mem_write_c;
    assign bus.reg_write = rst_n & reg_write_c;
    assign bus.illegal   = rst_n & illegal_c;
    assign bus.state     = state_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl. A per-instruction path model supplies the expected state and outputs for every cycle.
// The same model tracks the expected retire count.
module tb_mips_multicycle_ctrl;
    localparam int CNT_W = 4;

    typedef enum {K_LW, K_SW, K_R, K_BEQ, K_ADDI, K_J, K_ILL} kind_e;
    typedef struct {int st; bit mr;} step_t;
    typedef struct packed {
        logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic illegal;
    } outs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_ctrl_if #(.CNT_W(CNT_W)) bus ();
    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cnt_model = 0;
    step_t path[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit funct_supported(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return funct_supported(fn) ? K_R : K_ILL;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h04:   return K_BEQ;
            6'h08:   return K_ADDI;
            6'h02:   return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Output table: one row per state of the control sequence.
    function automatic outs_t expect_outs(input int st, input bit mr, input bit z, input logic [5:0] fn);
        outs_t o = '0;
        case (st)
            0:  begin o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010; o.ir_write = mr; o.pc_en = mr; end
            1:  begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            3:  o.iord = 1;
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            5:  begin o.iord = 1; o.mem_write = mr; end
            6:  begin o.alu_src_a = 1; o.alu_ctrl = rtype_alu(fn); end
            7:  begin o.reg_dst = 1; o.reg_write = 1; end
            8:  begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
            10: o.reg_write = 1;
            11: begin o.pc_en = 1; o.pc_src = 2'b10; end
            12: o.illegal = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic outs_t observed_outs();
        outs_t o;
        o.pc_en = bus.pc_en;         o.iord = bus.iord;
        o.mem_write = bus.mem_write; o.ir_write = bus.ir_write;
        o.reg_dst = bus.reg_dst;     o.mem_to_reg = bus.mem_to_reg;
        o.reg_write = bus.reg_write; o.alu_src_a = bus.alu_src_a;
        o.alu_src_b = bus.alu_src_b; o.alu_ctrl = bus.alu_ctrl;
        o.pc_src = bus.pc_src;       o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic logic [4:0] strobes();
        return {bus.pc_en, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal};
    endfunction

    // Expected cycle-by-cycle path of one instruction. fs and ms are the mem_ready stall counts in fetch and in the memory access.
    task automatic build_path(input kind_e k, input int fs, input int ms);
        path.delete();
        for (int i = 0; i < fs; i++) path.push_back('{0, 1'b0});
        path.push_back('{0, 1'b1});
        path.push_back('{1, 1'($urandom)});
        case (k)
            K_LW: begin
                path.push_back('{2, 1'($urandom)});
                for (int i = 0; i < ms; i++) path.push_back('{3, 1'b0});
                path.push_back('{3, 1'b1});
                path.push_back('{4, 1'($urandom)});
            end
            K_SW: begin
                path.push_back('{2, 1'($urandom)});
                for (int i = 0; i < ms; i++) path.push_back('{5, 1'b0});
                path.push_back('{5, 1'b1});
            end
            K_R: begin
                path.push_back('{6, 1'($urandom)});
                path.push_back('{7, 1'($urandom)});
            end
            K_BEQ:  path.push_back('{8, 1'($urandom)});
            K_ADDI: begin
                path.push_back('{9, 1'($urandom)});
                path.push_back('{10, 1'($urandom)});
            end
            K_J:    path.push_back('{11, 1'($urandom)});
            default: path.push_back('{12, 1'($urandom)});
        endcase
    endtask

    task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input bit z, input int fs, input int ms, input int cut);
        kind_e k = classify(op, fn);
        int    n;
        build_path(k, fs, ms);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        n = (cut < 0) ? path.size() : cut;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.mem_ready = path[i].mr;
            #1;
            check($sformatf("%s c%0d state", tag, i), 32'(bus.state), 32'(path[i].st));
            check($sformatf("%s c%0d outs", tag, i), 32'(observed_outs()),
                  32'(expect_outs(path[i].st, path[i].mr, z, fn)));
            check($sformatf("%s c%0d retired", tag, i), 32'(bus.retired), 32'(cnt_model));
        end
        if (cut < 0 && k != K_ILL) cnt_model = (cnt_model + 1) % (1 << CNT_W);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check({tag, " idle state"}, 32'(bus.state), 32'd0);
        check({tag, " idle retired"}, 32'(bus.retired), 32'(cnt_model));
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            bus.mem_ready = 1'($urandom);
            #1;
            check($sformatf("reset c%0d strobes", i), 32'(strobes()), 32'd0);
        end
        @(negedge clk);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset retired", 32'(bus.retired), 32'd0);
        cnt_model = 0;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        logic [5:0] op, fn;
        int         r;
        logic [5:0] rfuncts [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

        rst_n = 1'b0;
        bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        do_reset(2);

        run_instr("add", 6'h00, 6'h20, 1'b0, 0, 0, -1);
        idle_check("add");
        run_instr("lw_stall", 6'h23, 6'h11, 1'b0, 3, 3, -1);
        idle_check("lw_stall");
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, 0, 0, -1);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, 0, 0, -1);
        run_instr("ill_op3f", 6'h3F, 6'h20, 1'b0, 0, 0, -1);
        run_instr("ill_fn03", 6'h00, 6'h03, 1'b0, 0, 0, -1);
        idle_check("illegal");

        for (int t = 0; t < 60; t++) begin
            r  = $urandom_range(0, 7);
            fn = 6'($urandom);
            case (r)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: begin op = 6'h00; fn = rfuncts[$urandom_range(0, 4)]; end
                3: op = 6'h04;
                4: op = 6'h08;
                5: op = 6'h02;
                6: begin
                    op = 6'($urandom);
                    while (op == 6'h00 || classify(op, fn) != K_ILL) op = 6'($urandom);
                end
                default: begin
                    op = 6'h00;
                    while (funct_supported(fn)) fn = 6'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", t), op, fn, 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
        idle_check("random");

        // Reset arrives while sw is waiting in MEMWR. mem_ready is raised during reset, but the write must stay suppressed.
        run_instr("sw_rst", 6'h2B, 6'h00, 1'b0, 0, 1, 4);
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("sw_rst memwr state", 32'(bus.state), 32'd5);
        check("sw_rst mem_write", 32'(bus.mem_write), 32'd0);
        check("sw_rst strobes", 32'(strobes()), 32'd0);
        @(negedge clk);
        #1;
        check("sw_rst after state", 32'(bus.state), 32'd0);
        check("sw_rst after retired", 32'(bus.retired), 32'd0);
        cnt_model = 0;
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;

        for (int t = 0; t < (1 << CNT_W) - 1; t++)
            run_instr($sformatf("j_pre%0d", t), 6'h02, 6'($urandom), 1'($urandom), 0, 0, -1);
        idle_check("j_full");
        check("j_full retired", 32'(bus.retired), 32'((1 << CNT_W) - 1));
        run_instr("j_wrap", 6'h02, 6'h00, 1'b0, 0, 0, -1);
        idle_check("j_wrap");
        check("j_wrap retired zero", 32'(bus.retired), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback using the opcode (instr[31:26]) and funct (instr[5:0]) fields produced by the instruction field splitter, plus the ALU zero flag. It drives all datapath enables and mux selects, waits on a memory ready handshake, counts retired instructions and flags unsupported encodings.

Parameters:
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
opcode  in  6  instr[31:26] from IR
funct  in  6  instr[5:0] from IR
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC load enable, equal to pc_write | (branch & zero)
iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register: 0 = rt, 1 = rd
mem_to_reg  out  1  write data: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal  out  1  unsupported instruction pulse
state  out  4  current state encoding, for debug
retired  out  CNT_W  retired-instruction count

Behaviour:
- Supported opcodes: 0x00 R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), 0x23 lw, 0x2B sw, 0x04 beq, 0x08 addi, 0x02 j.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ILLEGAL 12. Encodings 13-15 go to FETCH on the next edge.
- Reset: when rst_n=0 at an edge, state <= FETCH and retired <= 0. While rst_n=0, pc_en, ir_write, mem_write, reg_write and illegal are forced to 0.
- Outputs are decoded combinationally from state. Strobes in FETCH, MEMRD and MEMWR are also gated by mem_ready. Any output not listed for a state is 0.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. When mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold FETCH with no strobes.
- DECODE: alu_src_a=0, alu_src_b=11, add. Next state by opcode:
  - lw/sw -> MEMADR
  - R-type with a supported funct -> RTEX
  - beq -> BEQEX
  - addi -> ADDIEX
  - j -> JEX
  - any other opcode or funct -> ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, add. Goes to MEMRD for lw, MEMWR for sw (opcode is held stable in IR).
- MEMRD: iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, then FETCH.
- MEMWR: iord=1, mem_write=mem_ready. Waits for mem_ready, then FETCH.
- RTEX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct, then RTWB.
- RTWB: reg_dst=1, mem_to_reg=0, reg_write=1, then FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, sub, branch=1, pc_src=01, then FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add, then ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, then FETCH.
- JEX: pc_write=1, pc_src=10, then FETCH.
- ILLEGAL: illegal=1 for exactly one cycle, no other strobes, then FETCH; retired is not incremented.
- Latency in cycles, assuming mem_ready=1 throughout: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Retire: retired increments by 1 on the edge that leaves MEMWB, RTWB, ADDIWB, BEQEX or JEX, and on the MEMWR edge when mem_ready=1. It wraps from all-ones to 0.
- Reset asserted mid-instruction aborts it: no retire, FETCH on the next edge.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.

Test Plan:
- Reset then add (opcode 0x00, funct 0x20), mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired=1.
- lw (0x23) with mem_ready low for 3 cycles in both FETCH and MEMRD -> no ir_write or pc_en while stalled; total 11 cycles; reg_write with mem_to_reg=1 in MEMWB; retired=1.
- beq (0x04), once with zero=1 and once with zero=0 -> pc_en=1 with pc_src=01 in BEQEX only when zero=1; retired=2.
- Opcode 0x3F, then opcode 0x00 with funct 0x03 -> each reaches ILLEGAL with a single-cycle illegal pulse; retired unchanged; back to FETCH.
- sw (0x2B) with rst_n driven low in MEMWR before mem_ready -> mem_write=0; state=0 and retired=0 after the edge.
- Preload via 2^CNT_W-1 j instructions (opcode 0x02), then one more j -> retired wraps to 0; pc_en=1 and pc_src=10 in each JEX.
